// File: rtl/pipe_collect.sv
// Collects N consecutive 16-bit pipeline results into one block and presents
// its sum, average, maximum and minimum over a valid/ready handshake.
module pipe_collect #(
  parameter int N     = 4,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] sum,
  output logic [15:0]      avg,
  output logic [15:0]      max,
  output logic [15:0]      min,
  output logic             busy,
  output logic             overrun
);

  localparam int LOG2N = $clog2(N);
  localparam int CNT_W = (LOG2N < 1) ? 1 : LOG2N;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc_p0, acc_upd;
  logic [15:0]      max_p0, min_p0, max_upd, min_upd;
  logic [CNT_W-1:0] cnt_p0;
  logic             take, last, restart;

  function automatic logic [15:0] avg_of(input logic [ACC_W-1:0] s);
    return 16'(s >> LOG2N);
  endfunction

  function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (b < a) ? b : a;
  endfunction

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    last      = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ACCUM;
      ACCUM: begin
        // start wins over a sample presented in the same cycle
        if (start) begin
          restart = 1'b1;
        end else if (in_valid) begin
          take = 1'b1;
          if (cnt_p0 == CNT_W'(N - 1)) begin
            last      = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_upd = acc_p0 + {{(ACC_W-16){1'b0}}, in_data};
    max_upd = max16(max_p0, in_data);
    min_upd = min16(min_p0, in_data);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == ACCUM);
      if (in_valid && state != ACCUM)
        overrun <= 1'b1;
      else if (start && state != DONE)
        overrun <= 1'b0;
    end
  end

  // Stage p0: running accumulation over the current block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p0 <= '0;
      max_p0 <= 16'h0000;
      min_p0 <= 16'hFFFF;
      cnt_p0 <= '0;
    end else if (state != ACCUM || restart) begin
      acc_p0 <= '0;
      max_p0 <= 16'h0000;
      min_p0 <= 16'hFFFF;
      cnt_p0 <= '0;
    end else if (take) begin
      acc_p0 <= acc_upd;
      max_p0 <= max_upd;
      min_p0 <= min_upd;
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // Stage p1: block summary, loaded with the Nth sample folded in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
      avg <= '0;
      max <= '0;
      min <= '0;
    end else if (last) begin
      sum <= acc_upd;
      avg <= avg_of(acc_upd);
      max <= max_upd;
      min <= min_upd;
    end
  end

endmodule

// File: tb/tb_pipe_collect.sv
// Bench for pipe_collect: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based block model.
module tb_pipe_collect;
  localparam int N     = 4;
  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0]      in_data = 16'd0;
  logic             out_valid, busy, overrun;
  logic [ACC_W-1:0] sum;
  logic [15:0]      avg, max, min;

  logic             start16 = 1'b0, in_valid16 = 1'b0, out_ready16 = 1'b1;
  logic [15:0]      in_data16 = 16'd0;
  logic             out_valid16, busy16, overrun16;
  logic [19:0]      sum16;
  logic [15:0]      avg16, max16, min16;

  pipe_collect #(.N(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid),
    .sum(sum), .avg(avg), .max(max), .min(min), .busy(busy), .overrun(overrun)
  );

  pipe_collect #(.N(16), .ACC_W(20)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .in_valid(in_valid16),
    .in_data(in_data16), .out_ready(out_ready16), .out_valid(out_valid16),
    .sum(sum16), .avg(avg16), .max(max16), .min(min16), .busy(busy16),
    .overrun(overrun16)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 collecting, 2 summary held
  int          mode = 0;
  logic        m_ovr = 1'b0;
  logic [31:0] e_sum = 0, e_avg = 0, e_max = 0, e_min = 0;
  logic [15:0] q[$];

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mode = 0; m_ovr = 1'b0; q.delete();
        e_sum = 0; e_avg = 0; e_max = 0; e_min = 0;
      end else begin
        case (mode)
          0: begin
            if (in_valid) m_ovr = 1'b1;
            if (start) begin
              mode = 1;
              q.delete();
              if (!in_valid) m_ovr = 1'b0;
            end
          end
          1: begin
            if (start) begin
              q.delete();
              m_ovr = 1'b0;
            end else if (in_valid) begin
              q.push_back(in_data);
              if (q.size() == N) begin
                int s;
                logic [15:0] mx, mn;
                s = 0; mx = 16'h0000; mn = 16'hFFFF;
                foreach (q[i]) begin
                  s += int'(q[i]);
                  if (q[i] > mx) mx = q[i];
                  if (q[i] < mn) mn = q[i];
                end
                e_sum = 32'(s);
                e_avg = 32'(s / N);
                e_max = 32'(mx);
                e_min = 32'(mn);
                q.delete();
                mode = 2;
              end
            end
          end
          default: begin
            if (in_valid) m_ovr = 1'b1;
            if (out_ready) mode = 0;
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_out_valid", 32'(out_valid), 32'(mode == 2));
      check("cmp_busy", 32'(busy), 32'(mode == 1));
      check("cmp_overrun", 32'(overrun), 32'(m_ovr));
      if (mode == 2) begin
        check("cmp_sum", 32'(sum), e_sum);
        check("cmp_avg", 32'(avg), e_avg);
        check("cmp_max", 32'(max), e_max);
        check("cmp_min", 32'(min), e_min);
      end
    end
  end

  task automatic drive(input logic s, input logic v, input logic [15:0] d);
    start = s; in_valid = v; in_data = d;
    @(posedge clk); #2;
  endtask

  task automatic summary_is(input string tag, input logic [31:0] s, input logic [31:0] a,
                            input logic [31:0] mx, input logic [31:0] mn);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), s);
    check({tag, "_avg"}, 32'(avg), a);
    check({tag, "_max"}, 32'(max), mx);
    check({tag, "_min"}, 32'(min), mn);
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'd0);
    check({tag, "_avg"}, 32'(avg), 32'd0);
    check({tag, "_max"}, 32'(max), 32'd0);
    check({tag, "_min"}, 32'(min), 32'd0);
  endtask

  task automatic async_reset();
    #1 reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    #1;
  endtask

  function automatic logic [15:0] pipe_fn(input int s, input int a, input int b, input int c);
    int r;
    r = (s != 0) ? (a + b) * c : (a - b) * c;
    return 16'(r);
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    all_zero("reset");

    // basic block, out_ready held high
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 16'd0);
    check("basic_busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b1, 16'd10);
    drive(1'b0, 1'b1, 16'd20);
    drive(1'b0, 1'b1, 16'd30);
    drive(1'b0, 1'b1, 16'd40);
    summary_is("basic", 32'd100, 32'd25, 32'd40, 32'd10);
    drive(1'b0, 1'b0, 16'd0);
    check("basic_drop", 32'(out_valid), 32'd0);

    // full scale
    drive(1'b1, 1'b0, 16'd0);
    repeat (4) drive(1'b0, 1'b1, 16'hFFFF);
    summary_is("full", 32'h3FFFC, 32'hFFFF, 32'hFFFF, 32'hFFFF);
    drive(1'b0, 1'b0, 16'd0);

    // backpressure and gaps
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 16'd5);
    drive(1'b0, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 16'd7);
    drive(1'b0, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 16'd3);
    drive(1'b0, 1'b1, 16'd9);
    summary_is("bp", 32'd24, 32'd6, 32'd9, 32'd3);
    repeat (3) begin
      drive(1'b0, 1'b0, 16'd0);
      summary_is("bp_hold", 32'd24, 32'd6, 32'd9, 32'd3);
    end
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 16'd0);
    check("bp_drop", 32'(out_valid), 32'd0);

    // restart inside a block, then overrun
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 16'd100);
    drive(1'b0, 1'b1, 16'd200);
    drive(1'b1, 1'b1, 16'd999);
    drive(1'b0, 1'b1, 16'd1);
    drive(1'b0, 1'b1, 16'd2);
    drive(1'b0, 1'b1, 16'd3);
    drive(1'b0, 1'b1, 16'd4);
    summary_is("restart", 32'd10, 32'd2, 32'd4, 32'd1);
    drive(1'b0, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 16'd77);
    check("ovr_set", 32'(overrun), 32'd1);
    drive(1'b1, 1'b0, 16'd0);
    check("ovr_clear", 32'(overrun), 32'd0);
    repeat (4) drive(1'b0, 1'b1, 16'd8);
    drive(1'b0, 1'b0, 16'd0);
    drive(1'b1, 1'b1, 16'd55);
    check("ovr_start_busy", 32'(busy), 32'd1);
    check("ovr_start_set", 32'(overrun), 32'd1);
    drive(1'b0, 1'b1, 16'd6);
    drive(1'b0, 1'b1, 16'd2);
    drive(1'b0, 1'b1, 16'd8);
    drive(1'b0, 1'b1, 16'd4);
    summary_is("ovr_blk", 32'd20, 32'd5, 32'd8, 32'd2);
    drive(1'b0, 1'b0, 16'd0);

    // asynchronous reset mid-block and while holding a summary
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 16'd1);
    drive(1'b0, 1'b1, 16'd2);
    async_reset();
    all_zero("rst_accum");
    reset = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 16'd9);
    drive(1'b0, 1'b1, 16'd8);
    drive(1'b0, 1'b1, 16'd7);
    drive(1'b0, 1'b1, 16'd6);
    summary_is("pre_rst", 32'd30, 32'd7, 32'd9, 32'd6);
    async_reset();
    all_zero("rst_done");
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    drive(1'b1, 1'b0, 16'd0);
    repeat (4) drive(1'b0, 1'b1, 16'd1);
    summary_is("post_rst", 32'd4, 32'd1, 32'd1, 32'd1);
    drive(1'b0, 1'b0, 16'd0);

    // N=16 fed through a two-cycle add/multiply pipeline
    begin
      logic v1, v2;
      logic [15:0] r1, r2;
      int waited;
      v1 = 1'b0; v2 = 1'b0; r1 = 16'd0; r2 = 16'd0;
      start16 = 1'b1;
      @(posedge clk); #2;
      start16 = 1'b0;
      check("n16_busy", 32'(busy16), 32'd1);
      for (int t = 0; t < 18; t++) begin
        in_valid16 = v2;
        in_data16  = r2;
        v2 = v1; r2 = r1;
        v1 = (t < 16);
        r1 = pipe_fn(1, 3, 2, 4);
        @(posedge clk); #2;
      end
      in_valid16 = 1'b0;
      waited = 0;
      while (!out_valid16 && waited < 8) begin
        @(posedge clk); #2;
        waited++;
      end
      check("n16_valid", 32'(out_valid16), 32'd1);
      check("n16_sum", 32'(sum16), 32'd320);
      check("n16_avg", 32'(avg16), 32'd20);
      check("n16_max", 32'(max16), 32'd20);
      check("n16_min", 32'(min16), 32'd20);
      check("n16_overrun", 32'(overrun16), 32'd0);
      @(posedge clk); #2;
      check("n16_drop", 32'(out_valid16), 32'd0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      out_ready = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       d = 16'hFFFF - 16'($urandom_range(0, 3));
        1:       d = 16'($urandom_range(0, 15));
        default: d = 16'($urandom);
      endcase
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
        reset = 1'b0;
        @(posedge clk); #2;
      end else begin
        drive($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, d);
      end
    end
    drive(1'b0, 1'b0, 16'd0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
